// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// Module   : bcd_serial_add_ctrl
// Purpose  : NDIG-digit BCD adder sequencer driving one shared digit adder,
//            least-significant digit first, one digit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
   input  logic              ci,
   output logic [3:0]        dig_a,
   output logic [3:0]        dig_b,
   output logic              dig_ci,
   input  logic [3:0]        dig_s,
   input  logic              dig_co,
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] sum,
   output logic              co,
   output logic              err
);

   localparam int                 c_IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NDIG - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [4*NDIG-1:0]   r_a;
   logic [4*NDIG-1:0]   r_b;
   logic [4*NDIG-1:0]   r_sum;
   logic                r_carry;
   logic                r_co;
   logic                r_err;
   logic [c_IDX_W-1:0]  r_idx;
   logic                w_err;

   // Flags any non-decimal digit on the live operand inputs.
   always_comb begin
      w_err = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
            w_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      dig_a        = 4'd0;
      dig_b        = 4'd0;
      dig_ci       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_ADD;
            end
         end
         S_ADD: begin
            dig_a  = r_a[{r_idx, 2'b00} +: 4];
            dig_b  = r_b[{r_idx, 2'b00} +: 4];
            dig_ci = r_carry;
            if (r_idx == c_LAST) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_co    <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= ci;
                  r_idx   <= '0;
                  r_err   <= w_err;
               end
            end
            S_ADD: begin
               // Sum is overwritten digit by digit; no clear on accept.
               r_sum[{r_idx, 2'b00} +: 4] <= dig_s;
               r_carry                    <= dig_co;
               if (r_idx == c_LAST) begin
                  r_co  <= dig_co;
                  r_idx <= '0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign co   = r_co;
   assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_bcd_serial_add_ctrl
// Purpose  : Directed self-checking bench for bcd_serial_add_ctrl with a
//            behavioural single-digit decimal adder on the shared-adder port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

   localparam int NDIG = 4;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [4*NDIG-1:0] a;
   logic [4*NDIG-1:0] b;
   logic              ci;
   logic [3:0]        dig_a;
   logic [3:0]        dig_b;
   logic              dig_ci;
   logic [3:0]        dig_s;
   logic              dig_co;
   logic              busy;
   logic              done;
   logic [4*NDIG-1:0] sum;
   logic              co;
   logic              err;

   int n_checks;
   int n_fail;

   bcd_serial_add_ctrl #(.NDIG(NDIG)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .ci     (ci),
      .dig_a  (dig_a),
      .dig_b  (dig_b),
      .dig_ci (dig_ci),
      .dig_s  (dig_s),
      .dig_co (dig_co),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .co     (co),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared single-digit decimal adder.
   always_comb begin
      logic [4:0] w_raw;
      w_raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, dig_ci};
      if (w_raw > 5'd9) begin
         dig_s  = 4'(w_raw - 5'd10);
         dig_co = 1'b1;
      end else begin
         dig_s  = w_raw[3:0];
         dig_co = 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Accepts one operation and checks the full accept-to-idle timeline.
   task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tci, input logic [15:0] esum, input logic eco,
                        input logic eerr);
      a = ta; b = tb_; ci = tci; start = 1'b1;
      tick();                       // E0 accept
      start = 1'b0;
      a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
      check_eq({tag, " busy@E0"}, busy, 1);
      check_eq({tag, " err@E0"}, err, eerr);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_eq($sformatf("%s done@E%0d", tag, k), done, (k == 4));
      end
      check_eq({tag, " sum"}, sum, esum);
      check_eq({tag, " co"}, co, eco);
      check_eq({tag, " err"}, err, eerr);
      tick();                       // E5 back to idle
      check_eq({tag, " busy@E5"}, busy, 0);
      check_eq({tag, " done@E5"}, done, 0);
      check_eq({tag, " sum hold"}, sum, esum);
   endtask

   initial begin
      logic [3:0] exp_da [4];
      logic [3:0] exp_db [4];
      logic       exp_dc [4];
      n_checks = 0;
      n_fail   = 0;
      start = 1'b0; a = '0; b = '0; ci = 1'b0;
      rst_n = 1'b0;
      #12;
      check_eq("rst busy", busy, 0);
      check_eq("rst done", done, 0);
      check_eq("rst sum", sum, 0);
      check_eq("rst co", co, 0);
      check_eq("rst err", err, 0);
      check_eq("rst dig", {dig_a, dig_b, 3'd0, dig_ci}, 0);
      rst_n = 1'b1;
      tick();

      do_op("add4567", 16'h4567, 16'h1234, 1'b0, 16'h5801, 1'b0, 1'b0);
      do_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

      // Per-cycle shared-adder drive.
      exp_da = '{4'd6, 4'd4, 4'd0, 4'd0};
      exp_db = '{4'd4, 4'd0, 4'd0, 4'd0};
      exp_dc = '{1'b0, 1'b1, 1'b0, 1'b0};
      a = 16'h0046; b = 16'h0004; ci = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("seq dig_a%0d", k), dig_a, exp_da[k]);
         check_eq($sformatf("seq dig_b%0d", k), dig_b, exp_db[k]);
         check_eq($sformatf("seq dig_ci%0d", k), dig_ci, exp_dc[k]);
         tick();
      end
      check_eq("seq done", done, 1);
      check_eq("seq sum", sum, 16'h0050);
      check_eq("seq dig idle", {dig_a, dig_b, 3'd0, dig_ci}, 0);
      tick();

      // Start held high: one accept per 6 cycles.
      a = 16'h1111; b = 16'h2222; ci = 1'b0; start = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check_eq($sformatf("hold busy@%0d", k), busy, ((k % 6) != 5));
         check_eq($sformatf("hold done@%0d", k), done, ((k % 6) == 4));
         if ((k % 6) == 4) check_eq($sformatf("hold sum@%0d", k), sum, 16'h3333);
      end
      start = 1'b0;
      tick();
      check_eq("hold stop", busy, 0);

      // Reset in the second ADD cycle.
      a = 16'h00A0; b = 16'h0001; ci = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("mid err set", err, 1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid busy", busy, 0);
      check_eq("mid done", done, 0);
      check_eq("mid sum", sum, 0);
      check_eq("mid co", co, 0);
      check_eq("mid err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq($sformatf("mid nodone%0d", k), done, 0);
      end
      do_op("post rst", 16'h4567, 16'h1234, 1'b0, 16'h5801, 1'b0, 1'b0);

      // Invalid digit flagged but computation still completes.
      do_op("err", 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1);
      do_op("err clr", 16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
